// File: rtl/pim_dma.sv
// pim_dma: single-channel DMA that streams words between the PIM buffer
// (master port 0) and the PIM array (master port 1). A small register file
// on the config port holds the source, destination and word count. A
// one-entry hold buffer covers read data that returns while the bus grant
// is low.
module pim_dma #(
   parameter int LEN_W = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_cfg_addr,
   input  logic        i_cfg_write,
   input  logic        i_cfg_read,
   input  logic [3:0]  i_cfg_size,
   input  logic [31:0] i_cfg_din,
   output logic [31:0] o_cfg_dout,
   output logic        o_req,
   input  logic        i_gnt,
   output logic [31:0] o_addr_0,
   output logic        o_write_0,
   output logic        o_read_0,
   output logic [3:0]  o_size_0,
   output logic [31:0] o_din_0,
   input  logic [31:0] i_dout_0,
   output logic [31:0] o_addr_1,
   output logic        o_write_1,
   output logic        o_read_1,
   output logic [3:0]  o_size_1,
   output logic [31:0] o_din_1,
   input  logic [31:0] i_dout_1,
   output logic        o_irq
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_n;
   logic [31:0]        src, dst;
   logic [LEN_W-1:0]   len, rd_cnt, wr_cnt;
   logic               dir, done, aborted;
   logic               rd_pend, hold_vld;
   logic [31:0]        hold_data;

   logic [2:0]         reg_sel;
   logic               busy, ctrl_wr, start_req, abort_req;
   logic               run_ok, rd_issue, wr_issue, last_wr;
   logic [31:0]        src_dout, wr_data, rd_addr, wr_addr, rdata;

   // The transfer size and address bits outside the register window carry no meaning here
   logic               unused_cfg;
   assign unused_cfg = ^{i_cfg_size, i_cfg_addr[31:5], i_cfg_addr[1:0]};

   assign reg_sel   = i_cfg_addr[4:2];
   assign busy      = (state == RUN);
   assign ctrl_wr   = i_cfg_write && (reg_sel == 3'd3);
   assign start_req = ctrl_wr && i_cfg_din[0];
   assign abort_req = ctrl_wr && i_cfg_din[2];

   // An abort in the same cycle suppresses every strobe so nothing moves after it
   assign run_ok   = (state == RUN) && i_gnt && !abort_req;
   assign rd_issue = run_ok && (rd_cnt < len) && !hold_vld;
   assign wr_issue = run_ok && (rd_pend || hold_vld);
   assign last_wr  = wr_issue && (wr_cnt == len - LEN_W'(1));
   assign src_dout = dir ? i_dout_1 : i_dout_0;
   assign wr_data  = hold_vld ? hold_data : src_dout;
   assign rd_addr  = src + (32'(rd_cnt) << 2);
   assign wr_addr  = dst + (32'(wr_cnt) << 2);
   assign o_req    = (state == RUN);
   assign o_irq    = (state == DONE);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_n;
   end

   // Next-state logic: a zero-length start completes at once without touching the bus
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start_req) state_n = (len == '0) ? DONE : RUN;
         RUN:  begin
                  if (abort_req)    state_n = IDLE;
                  else if (last_wr) state_n = DONE;
               end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Register file writes plus the sticky done/aborted flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         src     <= '0;
         dst     <= '0;
         len     <= '0;
         dir     <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         if (i_cfg_write && !busy) begin
            case (reg_sel)
               3'd0: src <= i_cfg_din;
               3'd1: dst <= i_cfg_din;
               3'd2: len <= i_cfg_din[LEN_W-1:0];
               3'd3: dir <= i_cfg_din[1];
               default: ;
            endcase
         end
         if (ctrl_wr) begin
            done    <= 1'b0;
            aborted <= 1'b0;
         end
         if (abort_req && (state == RUN)) aborted <= 1'b1;
         if ((state_n == DONE) && (state != DONE)) done <= 1'b1;
      end
   end

   // Register read mux; unmapped offsets return zero
   always_comb begin
      rdata = '0;
      case (reg_sel)
         3'd0: rdata = src;
         3'd1: rdata = dst;
         3'd2: rdata = 32'(len);
         3'd4: rdata = {29'b0, aborted, done, busy};
         default: rdata = '0;
      endcase
   end

   // Read data is registered and holds between reads
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)        o_cfg_dout <= '0;
      else if (i_cfg_read) o_cfg_dout <= rdata;
   end

   // Transfer datapath: counters, in-flight read marker and the one-word hold buffer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         rd_pend   <= 1'b0;
         hold_vld  <= 1'b0;
         hold_data <= '0;
      end else if ((state == IDLE) && start_req) begin
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         rd_pend  <= 1'b0;
         hold_vld <= 1'b0;
      end else if (state == RUN) begin
         if (rd_issue) rd_cnt <= rd_cnt + LEN_W'(1);
         if (wr_issue) wr_cnt <= wr_cnt + LEN_W'(1);
         rd_pend <= rd_issue;
         if (rd_pend && !wr_issue) begin
            hold_vld  <= 1'b1;
            hold_data <= src_dout;
         end else if (wr_issue && hold_vld) begin
            hold_vld <= 1'b0;
         end
         if (state_n != RUN) begin
            rd_pend  <= 1'b0;
            hold_vld <= 1'b0;
         end
      end
   end

   // Master ports: the source port reads, the destination port writes, an idle port stays all-zero
   always_comb begin
      o_addr_0 = '0; o_write_0 = 1'b0; o_read_0 = 1'b0; o_size_0 = '0; o_din_0 = '0;
      o_addr_1 = '0; o_write_1 = 1'b0; o_read_1 = 1'b0; o_size_1 = '0; o_din_1 = '0;
      if (rd_issue) begin
         if (!dir) begin
            o_read_0 = 1'b1; o_addr_0 = rd_addr; o_size_0 = 4'hF;
         end else begin
            o_read_1 = 1'b1; o_addr_1 = rd_addr; o_size_1 = 4'hF;
         end
      end
      if (wr_issue) begin
         if (!dir) begin
            o_write_1 = 1'b1; o_addr_1 = wr_addr; o_din_1 = wr_data; o_size_1 = 4'hF;
         end else begin
            o_write_0 = 1'b1; o_addr_0 = wr_addr; o_din_0 = wr_data; o_size_0 = 4'hF;
         end
      end
   end

endmodule

// File: doc/pim_dma.md
PIM_DMA -- requirements
Module: pim_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning width of the word-count register and counters.
REQ-002 SHALL have i_clk, input, 1, the clock; reset i_rst_n, asynchronous, active-low; clock i_clk.
REQ-003 SHALL have i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have config slave port: i_cfg_addr in 32, i_cfg_write in 1, i_cfg_read in 1, i_cfg_size in 4, i_cfg_din in 32, o_cfg_dout out 32.
REQ-005 SHALL have o_req out 1 (bus request) and i_gnt in 1 (bus grant, may drop on any cycle).
REQ-006 SHALL have master port 0 (PIM buffer side): o_addr_0 out 32, o_write_0 out 1, o_read_0 out 1, o_size_0 out 4, o_din_0 out 32, i_dout_0 in 32.
REQ-007 SHALL have master port 1 (PIM side), signals identical to port 0 with suffix _1.
REQ-008 SHALL have o_irq, output, 1, one-cycle completion pulse.

Function
REQ-009 SHALL decode registers on i_cfg_addr[4:2]: 0 SRC, 1 DST, 2 LEN (LEN_W bits, zero-extended on read), 3 CTRL, 4 STATUS; other offsets read 0, writes ignored.
REQ-010 CTRL write SHALL decode: bit0 START (self-clearing), bit1 DIR (stored; 0 = port0 read/port1 write, 1 = port1 read/port0 write), bit2 ABORT (self-clearing).
REQ-011 STATUS SHALL read {29'b0, aborted, done, busy}; any CTRL write clears done and aborted.
REQ-012 Config reads SHALL have 1-cycle latency: o_cfg_dout registered from the address sampled on i_cfg_read; it holds its value when no read occurs.
REQ-013 SRC/DST/LEN/DIR writes while busy SHALL be ignored.
REQ-014 FSM states: IDLE, RUN, DONE; IDLE->RUN on START with LEN!=0; IDLE->DONE on START with LEN==0, with no bus access.
REQ-015 RUN->DONE on the cycle the LEN-th write is issued; DONE->IDLE unconditionally after 1 cycle; o_irq=1 and done set during DONE.
REQ-016 START in RUN or DONE SHALL be ignored.
REQ-017 ABORT in RUN SHALL force IDLE next cycle, set aborted, deassert o_req, and issue no further strobes; o_irq SHALL NOT pulse.
REQ-018 o_req SHALL be 1 exactly while in RUN.
REQ-019 Read/write strobes SHALL assert only in cycles with RUN and i_gnt=1; o_size on an active port SHALL be 4'hF; every output of an idle port SHALL be 0.
REQ-020 Read issue: granted cycle, rd_cnt<LEN, hold buffer empty -> read on source port, address SRC+4*rd_cnt; rd_cnt increments.
REQ-021 Read data SHALL be taken from source i_dout exactly one cycle after the read strobe, whatever the grant in that cycle.
REQ-022 If i_gnt=1 in that cycle, the data SHALL be written the same cycle on the destination port: address DST+4*wr_cnt, din = the data; wr_cnt increments.
REQ-023 If i_gnt=0 in that cycle, the data SHALL be captured into a 1-entry hold buffer.
REQ-024 While the hold buffer is valid, the next granted cycle SHALL write from it, SHALL issue no read, and SHALL clear it.
REQ-025 Steady state with continuous grant: one word per cycle; LEN words complete in LEN+1 granted cycles after entering RUN.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32 (wrap-around, no error); counters are LEN_W bits; LEN max 2^LEN_W-1.
REQ-027 Port 0 and port 1 SHALL be driven in the same cycle (read on one, write on the other); neither port ever carries read and write together.

Reset
REQ-028 On i_rst_n low, asynchronously: FSM IDLE; SRC, DST, LEN, DIR, counters, hold buffer, o_cfg_dout, done, aborted = 0; all outputs 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no further strobes; a pending read response SHALL be discarded.

Verification
REQ-030 SRC=0x2000_0000, DST=0x4000_0000, LEN=4, DIR=0, START, gnt=1 -> reads 0x2000_0000..0x2000_000C on port0 in cycles 1-4 after RUN entry; writes to 0x4000_0000..0x4000_000C on port1 in cycles 2-5, data matching; o_irq pulses once; STATUS=0x2.
REQ-031 LEN=0, START -> DONE next cycle, o_irq pulse, o_req never 1, no strobes.
REQ-032 LEN=3, gnt=0 in the cycle after the 2nd read -> word 2 held; the next granted cycle writes it with no read; all 3 words arrive in order at correct addresses.
REQ-033 DIR=1, SRC=0x4000_0010, DST=0x2000_4000, LEN=2 -> port1 reads, port0 writes 0x2000_4000 and 0x2000_4004.
REQ-034 START again mid-transfer -> ignored; ABORT after 2 writes -> IDLE, STATUS=0x4, no o_irq.
REQ-035 i_rst_n low during RUN with LEN=8 -> all outputs 0 immediately; o_cfg_dout=0; registers read 0 after release.
